// File: rtl/commit_trace_fifo.sv
// Retirement monitor: captures one commit record per retired instruction, tags it with an
// instruction number and buffers it for a valid/ready consumer until the halt record drains.
module commit_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [15:0]      c_pc,
  input  logic [15:0]      c_inst,
  input  logic             c_regwrite,
  input  logic [2:0]       c_wreg,
  input  logic [15:0]      c_wdata,
  input  logic             c_memread,
  input  logic             c_memwrite,
  input  logic [15:0]      c_memaddr,
  input  logic [15:0]      c_memdata,
  input  logic             c_halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_inum,
  output logic [86:0]      out_rec,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic             done,
  output logic [31:0]      cycle_count
);

  localparam int REC_W = 87;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [CNT_W-1:0]   inum_q, inum_d;
  logic               out_valid_q, out_valid_d;
  logic [REC_W-1:0]   out_rec_q, out_rec_d;
  logic [CNT_W-1:0]   out_inum_q, out_inum_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;
  logic               done_q, done_d;
  logic [31:0]        cycle_count_q, cycle_count_d;

  logic [REC_W-1:0]   rec_mem_q [DEPTH];
  logic [CNT_W-1:0]   inum_mem_q [DEPTH];

  logic [REC_W-1:0]   in_rec_s;
  logic [PTR_W:0]     count_after_pop_s;
  logic               full_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_s;

  // Next-state logic for pointers, counters, FSM and the registered head-of-queue outputs
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inum_d        = inum_q;
    overflow_d    = overflow_q;
    drop_count_d  = drop_count_q;
    cycle_count_d = cycle_count_q;

    in_rec_s = {c_pc, c_inst, c_regwrite, c_wreg, c_wdata, c_memread, c_memwrite,
                c_memaddr, c_memdata, c_halt};
    full_s   = (count_q == FULL_CNT);
    pop_s    = out_valid_q & out_ready;
    accept_s = commit_valid & (state_q == ST_RUN);
    push_s   = accept_s & (~full_s | pop_s);
    drop_s   = accept_s & full_s & ~pop_s;
    count_after_pop_s = count_q - (PTR_W+1)'(pop_s);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // Dropped commits still consume a number so gaps show up downstream.
    if (accept_s) begin
      inum_d = inum_q + CNT_W'(1);
    end else begin
      inum_d = inum_q;
    end

    overflow_d = overflow_q | drop_s;
    if (drop_s && (drop_count_q != {CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end else begin
      drop_count_d = drop_count_q;
    end

    // A halt ends capture even if its own record was dropped.
    case (state_q)
      ST_RUN: begin
        if (accept_s && c_halt) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (count_d == (PTR_W+1)'(0)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase

    if (state_q != ST_DONE) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end else begin
      cycle_count_d = cycle_count_q;
    end

    done_d      = (state_d == ST_DONE);
    out_valid_d = (count_d != (PTR_W+1)'(0)) & (state_d != ST_DONE);

    // The new head is either already stored or is the record entering an otherwise empty queue.
    if (count_d == (PTR_W+1)'(0)) begin
      out_rec_d  = {REC_W{1'b0}};
      out_inum_d = {CNT_W{1'b0}};
    end else if (push_s && (count_after_pop_s == (PTR_W+1)'(0))) begin
      out_rec_d  = in_rec_s;
      out_inum_d = inum_q;
    end else begin
      out_rec_d  = rec_mem_q[rd_ptr_d];
      out_inum_d = inum_mem_q[rd_ptr_d];
    end
  end

  // Control, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {(PTR_W+1){1'b0}};
      inum_q        <= {CNT_W{1'b0}};
      out_valid_q   <= 1'b0;
      out_rec_q     <= {REC_W{1'b0}};
      out_inum_q    <= {CNT_W{1'b0}};
      overflow_q    <= 1'b0;
      drop_count_q  <= {CNT_W{1'b0}};
      done_q        <= 1'b0;
      cycle_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inum_q        <= inum_d;
      out_valid_q   <= out_valid_d;
      out_rec_q     <= out_rec_d;
      out_inum_q    <= out_inum_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
      done_q        <= done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Record storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rec_mem_q[i]  <= {REC_W{1'b0}};
        inum_mem_q[i] <= {CNT_W{1'b0}};
      end
    end else if (push_s) begin
      rec_mem_q[wr_ptr_q]  <= in_rec_s;
      inum_mem_q[wr_ptr_q] <= inum_q;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rec     = out_rec_q;
  assign out_inum    = out_inum_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Self-checking bench for commit_trace_fifo: a behavioural queue model predicts every output each cycle.
module tb_commit_trace_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_valid = 1'b0;
  logic [15:0] c_pc = 16'd0, c_inst = 16'd0, c_wdata = 16'd0, c_memaddr = 16'd0, c_memdata = 16'd0;
  logic        c_regwrite = 1'b0, c_memread = 1'b0, c_memwrite = 1'b0, c_halt = 1'b0;
  logic [2:0]  c_wreg = 3'd0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_inum;
  logic [86:0] out_rec;
  logic        overflow, done;
  logic [15:0] drop_count;
  logic [31:0] cycle_count;

  commit_trace_fifo #(.DEPTH(8), .PTR_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid),
    .c_pc(c_pc), .c_inst(c_inst), .c_regwrite(c_regwrite), .c_wreg(c_wreg), .c_wdata(c_wdata),
    .c_memread(c_memread), .c_memwrite(c_memwrite), .c_memaddr(c_memaddr), .c_memdata(c_memdata),
    .c_halt(c_halt), .out_valid(out_valid), .out_ready(out_ready), .out_inum(out_inum),
    .out_rec(out_rec), .overflow(overflow), .drop_count(drop_count), .done(done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] inum;
    logic [86:0] rec;
  } exp_t;

  typedef struct {
    logic        cv;
    logic [15:0] pc;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_inum;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] m_inum = 16'd0;
  int          m_state = 0;
  logic        m_over = 1'b0;
  logic [15:0] m_drop = 16'd0;
  logic [31:0] m_cyc = 32'd0;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[5];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [86:0] pack_rec();
    return {c_pc, c_inst, c_regwrite, c_wreg, c_wdata, c_memread, c_memwrite,
            c_memaddr, c_memdata, c_halt};
  endfunction

  task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] inst,
                       input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                       input logic mr, input logic mw, input logic [15:0] ma,
                       input logic [15:0] md, input logic h);
    commit_valid = v; c_pc = pc; c_inst = inst; c_regwrite = rw; c_wreg = wr; c_wdata = wd;
    c_memread = mr; c_memwrite = mw; c_memaddr = ma; c_memdata = md; c_halt = h;
  endtask

  task automatic alu_commit(input logic v, input logic [15:0] pc);
    drive(v, pc, 16'h1200 ^ pc, 1'b1, 3'd1, 16'h0005 + pc, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
  endtask

  // Compare outputs against the model, then advance model and DUT one clock.
  task automatic step();
    logic m_valid, pop, push, drop, run;
    exp_t e;
    m_valid = (sb.size() > 0) && (m_state != 2);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_inum", out_inum, sb[0].inum);
      check("out_rec", out_rec, sb[0].rec);
    end
    check("overflow", overflow, m_over);
    check("drop_count", drop_count, m_drop);
    check("done", done, m_state == 2);
    check("cycle_count", cycle_count, m_cyc);
    if (rst) begin
      sb.delete(); m_inum = 16'd0; m_state = 0; m_over = 1'b0; m_drop = 16'd0; m_cyc = 32'd0;
    end else begin
      run  = (m_state == 0);
      pop  = m_valid && out_ready;
      push = commit_valid && run && ((sb.size() < DEPTH) || pop);
      drop = commit_valid && run && !push;
      if (m_state != 2) m_cyc = m_cyc + 32'd1;
      if (pop) void'(sb.pop_front());
      if (push) begin
        e.inum = m_inum; e.rec = pack_rec(); sb.push_back(e);
      end
      if (commit_valid && run) begin
        m_inum = m_inum + 16'd1;
        if (c_halt) m_state = 1;
      end else if (m_state == 1 && sb.size() == 0) begin
        m_state = 2;
      end
      if (drop) begin
        m_over = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_commit(1'b0, 16'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{cv: 1'b1, pc: 16'h0000, ready: 1'b1, exp_valid: 1'b0, exp_inum: 16'd0};
    tbl[1] = '{cv: 1'b1, pc: 16'h0002, ready: 1'b1, exp_valid: 1'b1, exp_inum: 16'd0};
    tbl[2] = '{cv: 1'b1, pc: 16'h0004, ready: 1'b1, exp_valid: 1'b1, exp_inum: 16'd1};
    tbl[3] = '{cv: 1'b0, pc: 16'h0000, ready: 1'b1, exp_valid: 1'b1, exp_inum: 16'd2};
    tbl[4] = '{cv: 1'b0, pc: 16'h0000, ready: 1'b1, exp_valid: 1'b0, exp_inum: 16'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset then three register-writing commits.
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].cv, tbl[i].pc, 16'h1240, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
      out_ready = tbl[i].ready;
      check("tbl_valid", out_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check("tbl_inum", out_inum, tbl[i].exp_inum);
      step();
    end

    // Backpressure to full with two drops, drain, then the next number is 10.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alu_commit(1'b1, 16'h0100 + 16'(2 * i));
      step();
    end
    alu_commit(1'b0, 16'd0);
    check("bp_overflow", overflow, 1'b1);
    check("bp_drops", drop_count, 16'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    alu_commit(1'b1, 16'h0200);
    step();
    alu_commit(1'b0, 16'd0);
    check("bp_next_inum", out_inum, 16'd10);
    step();

    // Simultaneous push and pop while full, across pointer wrap.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alu_commit(1'b1, 16'h0300 + 16'(2 * i));
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu_commit(1'b1, 16'h0400 + 16'(2 * i));
      step();
    end
    alu_commit(1'b0, 16'd0);
    check("full_pp_drops", drop_count, 16'd0);
    for (int i = 0; i < 9; i++) step();

    // Store, halt, ignored commits, then done with frozen cycle count.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 16'h0020, 16'h3ABC, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    step();
    drive(1'b1, 16'h0022, 16'hF000, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      alu_commit(1'b1, 16'h0030 + 16'(2 * i));
      step();
    end
    alu_commit(1'b0, 16'd0);
    for (int k = 0; k < 20 && !done; k++) step();
    check("done_reached", done, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // Reset with four buffered entries and overflow set.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      alu_commit(1'b1, 16'h0500 + 16'(2 * i));
      step();
    end
    alu_commit(1'b0, 16'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    check("pre_rst_overflow", overflow, 1'b1);
    do_reset();
    check("rst_valid", out_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drops", drop_count, 16'd0);
    check("rst_cycles", cycle_count, 32'd0);
    out_ready = 1'b1;
    alu_commit(1'b1, 16'h0600);
    step();
    alu_commit(1'b0, 16'd0);
    check("rst_first_inum", out_inum, 16'd0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
